// File: rtl/dp_sram_pkg.sv
// rtl/dp_sram_pkg.sv - shared types and limits for the dual-port SRAM
package dp_sram_pkg;

  typedef enum logic {
    WRITE_FIRST = 1'b0,
    READ_FIRST  = 1'b1
  } rdw_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_e;

  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/dp_sram_rdpipe.sv
// rtl/dp_sram_rdpipe.sv - per-port read response pipeline, RD_LAT stages
module dp_sram_rdpipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [RD_LAT-1:0] r_vld;
  logic [DATA_W-1:0] r_dat [RD_LAT];

  // Data stages only load behind a valid beat so the output holds between responses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        r_dat[k] <= '0;
      end
    end else begin
      r_vld[0] <= i_valid;
      if (i_valid) begin
        r_dat[0] <= i_data;
      end
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) begin
          r_dat[k] <= r_dat[k-1];
        end
      end
    end
  end

  assign o_valid = r_vld[RD_LAT-1];
  assign o_data  = r_dat[RD_LAT-1];

endmodule

// File: rtl/dp_sram_param.sv
// rtl/dp_sram_param.sv - parametrised true dual-port SRAM; optional power-up clear via CLEAR_ON_RESET_EN
module dp_sram_param
  import dp_sram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic                a_rvalid,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                coll,
  output logic                init_busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W / 8;

  generate
    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX || (DATA_W % 8) != 0) begin : g_bad_param
      $error("dp_sram_param: RD_LAT must be 1..2 and DATA_W a multiple of 8");
    end
  endgenerate

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_coll;
  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_a_acc, w_b_acc, w_a_wr, w_b_wr, w_same;
  logic [DATA_W-1:0] w_a_final, w_b_final, w_a_resp, w_b_resp;

  assign w_a_acc = a_req & ~w_busy;
  assign w_b_acc = b_req & ~w_busy;
  assign w_a_wr  = w_a_acc & a_we;
  assign w_b_wr  = w_b_acc & b_we;
  assign w_same  = (a_addr == b_addr);

  // Word each address will hold after this edge; port A owns bytes both ports enable
  always_comb begin
    w_a_final = r_mem[a_addr];
    w_b_final = r_mem[b_addr];
    for (int i = 0; i < NB; i++) begin
      if (w_a_wr && a_be[i]) begin
        w_a_final[i*8 +: 8] = a_wdata[i*8 +: 8];
      end else if (w_b_wr && w_same && b_be[i]) begin
        w_a_final[i*8 +: 8] = b_wdata[i*8 +: 8];
      end
      if (w_a_wr && w_same && a_be[i]) begin
        w_b_final[i*8 +: 8] = a_wdata[i*8 +: 8];
      end else if (w_b_wr && b_be[i]) begin
        w_b_final[i*8 +: 8] = b_wdata[i*8 +: 8];
      end
    end
  end

  assign w_a_resp = (a_we || RDW_MODE == int'(WRITE_FIRST)) ? w_a_final : r_mem[a_addr];
  assign w_b_resp = (b_we || RDW_MODE == int'(WRITE_FIRST)) ? w_b_final : r_mem[b_addr];

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end
    for (int i = 0; i < NB; i++) begin
      if (w_a_wr && a_be[i]) begin
        r_mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
      end
      if (w_b_wr && b_be[i] && !(w_a_wr && w_same && a_be[i])) begin
        r_mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_coll <= 1'b0;
    end else begin
      r_coll <= w_a_wr & w_b_wr & w_same & (|(a_be & b_be));
    end
  end

  assign coll = r_coll;

`ifdef CLEAR_ON_RESET_EN
  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_clr_we    = 1'b0;
    case (r_state)
      IDLE:  w_state_nxt = CLEAR;
      CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_addr == '1) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_busy = 1'b0;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_clr_addr = r_clr_addr;
  assign init_busy  = (r_state == CLEAR);
`else
  assign w_busy     = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
  assign init_busy  = 1'b0;
`endif

  dp_sram_rdpipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rdpipe_a (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_a_acc),
    .i_data  (w_a_resp),
    .o_valid (a_rvalid),
    .o_data  (a_rdata)
  );

  dp_sram_rdpipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rdpipe_b (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_b_acc),
    .i_data  (w_b_resp),
    .o_valid (b_rvalid),
    .o_data  (b_rdata)
  );

endmodule
